bcd2bin_seq: RTL and testbench

Multi-cycle, parametrised BCD-to-binary converter using the reverse double-dabble algorithm. It performs one shift-and-correct iteration per clock, which keeps the area at one correction stage regardless of digit count. Input and output use valid/ready handshakes, and malformed BCD digits are flagged. It sits between the BCD keypad/display front-end and the binary arithmetic datapath. It replaces the purely combinational converter wherever `DIGITS` > 2 would make the combinational correction chain too long.

---
 rtl/bcd_pkg.sv | 38 +++
 rtl/bcd_dabble_step.sv | 36 +++
 rtl/bcd2bin_seq.sv | 160 ++++++++++++++++
 tb/tb_bcd2bin_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : bcd_pkg                                                    |
// | Shared types and helpers for the BCD-to-binary converters.           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package bcd_pkg;

  // Largest value a legal BCD nibble may hold.
  localparam int BCD_MAX_DIGIT = 9;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Binary width needed to hold any DIGITS-digit decimal value:
  // ceil(log2(10**digits)), i.e. the number of k with 2**k < 10**digits.
  function automatic int bin_width(input int digits);
    longint unsigned p;
    int              w;
    p = 64'd1;
    w = 0;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    for (int k = 0; k < 63; k++) begin
      if ((64'd1 << k) < p) begin
        w = k + 1;
      end
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dabble_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bcd_dabble_step                                            |
// | One reverse double-dabble iteration: shift {bcd, acc} right by one,  |
// | then subtract 3 from every BCD nibble that ends up >= 8.             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module bcd_dabble_step #(
  parameter int DIGITS = 3
) (
  input  logic [8*DIGITS-1:0] i_bcd_acc,
  output logic [8*DIGITS-1:0] o_bcd_acc
);

  localparam int BCD_W = 4 * DIGITS;

  logic [2*BCD_W-1:0] w_shifted;

  // The LSB of the BCD field falls into the MSB of the accumulator.
  assign w_shifted = i_bcd_acc >> 1;

  // Accumulator half passes through untouched.
  assign o_bcd_acc[BCD_W-1:0] = w_shifted[BCD_W-1:0];

  // Per-nibble correction; a shifted legal nibble is at most 12, so
  // subtracting 3 never borrows out of the nibble.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_nib
      logic [3:0] w_nib;
      assign w_nib = w_shifted[BCD_W+4*i +: 4];
      assign o_bcd_acc[BCD_W+4*i +: 4] = (w_nib >= 4'd8) ? (w_nib - 4'd3) : w_nib;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/bcd2bin_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bcd2bin_seq                                                |
// | Multi-cycle BCD-to-binary converter, one dabble step per clock,      |
// | valid/ready on both sides, malformed-digit flag.                     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = bin_width(DIGITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] in_bcd,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BIN_W-1:0]    out_bin,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BCD_W > 1) ? $clog2(BCD_W) : 1;

  localparam logic [CNT_W-1:0] c_last = CNT_W'(BCD_W - 1);

  state_e               state_q, state_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BCD_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [BIN_W-1:0]     out_bin_q, out_bin_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;

  logic                 w_bad_digit;
  logic [2*BCD_W-1:0]   w_step;

  // Flag any incoming nibble above the largest decimal digit.
  always_comb begin
    w_bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (in_bcd[4*i +: 4] > 4'(BCD_MAX_DIGIT)) begin
        w_bad_digit = 1'b1;
      end
    end
  end

  // Single shared correction stage, fed from the working registers.
  bcd_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .i_bcd_acc ({bcd_q, acc_q}),
    .o_bcd_acc (w_step)
  );

  // Next-state and next-output logic for the control FSM.
  // A malformed input still spends one cycle in CONV (which performs no
  // iteration) so that the error result appears one edge after acceptance.
  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_bin_d   = out_bin_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          bcd_d      = in_bcd;
          acc_d      = '0;
          cnt_d      = '0;
          err_d      = w_bad_digit;
          state_d    = CONV;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      CONV: begin
        if (err_q) begin
          acc_d       = '0;
          out_bin_d   = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          bcd_d = w_step[2*BCD_W-1:BCD_W];
          acc_d = w_step[BCD_W-1:0];
          if (cnt_q == c_last) begin
            // Last iteration: publish the result straight from the step.
            out_bin_d   = w_step[BIN_W-1:0];
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        // Outputs hold while downstream stalls; handoff returns to IDLE.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_bin_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_bin_q   <= out_bin_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_bin   = out_bin_q;
  assign out_err   = err_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_bcd2bin_seq                                             |
// | Self-checking bench for bcd2bin_seq at DIGITS = 1, 3 and 4.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_bcd2bin_seq;

  logic clk;
  logic rst_n;

  logic [3:0]  in_bcd1;  logic in_valid1, in_ready1, out_err1, out_valid1, out_ready1, busy1;
  logic [3:0]  out_bin1;
  logic [11:0] in_bcd3;  logic in_valid3, in_ready3, out_err3, out_valid3, out_ready3, busy3;
  logic [9:0]  out_bin3;
  logic [15:0] in_bcd4;  logic in_valid4, in_ready4, out_err4, out_valid4, out_ready4, busy4;
  logic [13:0] out_bin4;

  int errors = 0;
  int checks = 0;

  bcd2bin_seq #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_bcd(in_bcd1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_bin(out_bin1), .out_err(out_err1), .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1));

  bcd2bin_seq #(.DIGITS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_bcd(in_bcd3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_bin(out_bin3), .out_err(out_err3), .out_valid(out_valid3), .out_ready(out_ready3), .busy(busy3));

  bcd2bin_seq #(.DIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_bcd(in_bcd4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_bin(out_bin4), .out_err(out_err4), .out_valid(out_valid4), .out_ready(out_ready4), .busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance access ----------------
  function automatic logic rdy(input int d);
    case (d)
      1:       return in_ready1;
      3:       return in_ready3;
      default: return in_ready4;
    endcase
  endfunction

  function automatic logic vld(input int d);
    case (d)
      1:       return out_valid1;
      3:       return out_valid3;
      default: return out_valid4;
    endcase
  endfunction

  function automatic logic erf(input int d);
    case (d)
      1:       return out_err1;
      3:       return out_err3;
      default: return out_err4;
    endcase
  endfunction

  function automatic logic [13:0] bin(input int d);
    case (d)
      1:       return 14'(out_bin1);
      3:       return 14'(out_bin3);
      default: return out_bin4;
    endcase
  endfunction

  task automatic set_in(input int d, input logic [15:0] b, input logic v);
    case (d)
      1:       begin in_bcd1 = b[3:0];  in_valid1 = v; end
      3:       begin in_bcd3 = b[11:0]; in_valid3 = v; end
      default: begin in_bcd4 = b;       in_valid4 = v; end
    endcase
  endtask

  task automatic set_ordy(input int d, input logic r);
    case (d)
      1:       out_ready1 = r;
      3:       out_ready3 = r;
      default: out_ready4 = r;
    endcase
  endtask

  // ---------------- reference model ----------------
  // Decimal value of the digit string, or error when any digit exceeds 9.
  task automatic ref_conv(input int d, input logic [15:0] b, output int val, output bit er);
    int dig;
    val = 0;
    er  = 1'b0;
    for (int i = d - 1; i >= 0; i--) begin
      dig = int'(b[4*i +: 4]);
      if (dig > 9) er = 1'b1;
      val = val * 10 + dig;
    end
    if (er) val = 0;
  endtask

  function automatic logic [15:0] rand_bcd(input int d, input bit bad);
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < d; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
    if (bad) b[4*$urandom_range(0, d - 1) +: 4] = 4'($urandom_range(10, 15));
    return b;
  endfunction

  // ---------------- driver ----------------
  // Offers one input, scrambles in_bcd after acceptance, measures edges
  // from acceptance to out_valid, optionally stalls out_ready, then hands off.
  task automatic convert(input int d, input logic [15:0] b, input int stall,
                         output int wt, output int lat, output int rdy_seen, output int stall_bad,
                         output logic [13:0] res, output logic er,
                         output logic v_after, output logic r_after);
    wt = 0; lat = 0; rdy_seen = 0; stall_bad = 0;
    set_in(d, b, 1'b1);
    set_ordy(d, stall == 0);
    while (!rdy(d) && wt < 100) begin
      @(posedge clk); #1; wt++;
    end
    @(posedge clk); #1;
    set_in(d, 16'($urandom), 1'b0);
    while (!vld(d) && lat < 100) begin
      if (rdy(d)) rdy_seen++;
      @(posedge clk); #1; lat++;
    end
    res = bin(d);
    er  = erf(d);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (!vld(d) || bin(d) !== res || erf(d) !== er || rdy(d)) stall_bad++;
    end
    set_ordy(d, 1'b1);
    @(posedge clk); #1;
    v_after = vld(d);
    r_after = rdy(d);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    checks++; if (in_ready3 !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready3); end
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid3); end
    checks++; if (out_err3 !== 1'b0)   begin errors++; $display("FAIL reset_out_err: got %b expected 0", out_err3); end
    checks++; if (out_bin3 !== 10'd0)  begin errors++; $display("FAIL reset_out_bin: got %0d expected 0", out_bin3); end
    checks++; if (busy3 !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy3); end
  endtask

  task automatic test_max;
    int wt, lat, rs, sb; logic [13:0] res; logic er, va, ra;
    convert(3, 16'h0999, 0, wt, lat, rs, sb, res, er, va, ra);
    checks++; if (res !== 14'd999) begin errors++; $display("FAIL max_bin: got %0d expected 999", res); end
    checks++; if (er !== 1'b0)     begin errors++; $display("FAIL max_err: got %b expected 0", er); end
    checks++; if (lat != 12)       begin errors++; $display("FAIL max_latency: got %0d expected 12", lat); end
    checks++; if (va !== 1'b0)     begin errors++; $display("FAIL max_valid_one_cycle: got %b expected 0", va); end
    checks++; if (rs != 0)         begin errors++; $display("FAIL max_ready_while_busy: got %0d expected 0", rs); end
  endtask

  task automatic test_back_to_back;
    int wt, lat, rs, sb; logic [13:0] res; logic er, va, ra;
    convert(3, 16'h0000, 0, wt, lat, rs, sb, res, er, va, ra);
    checks++; if (res !== 14'd0) begin errors++; $display("FAIL b2b_first_bin: got %0d expected 0", res); end
    checks++; if (ra !== 1'b1)   begin errors++; $display("FAIL b2b_ready_after_handoff: got %b expected 1", ra); end
    convert(3, 16'h0255, 0, wt, lat, rs, sb, res, er, va, ra);
    checks++; if (res !== 14'd255) begin errors++; $display("FAIL b2b_second_bin: got %0d expected 255", res); end
    checks++; if (wt != 0)         begin errors++; $display("FAIL b2b_accept_wait: got %0d expected 0", wt); end
    checks++; if (lat != 12)       begin errors++; $display("FAIL b2b_latency: got %0d expected 12", lat); end
  endtask

  task automatic test_error;
    int wt, lat, rs, sb; logic [13:0] res; logic er, va, ra;
    convert(3, 16'h01A7, 0, wt, lat, rs, sb, res, er, va, ra);
    checks++; if (res !== 14'd0) begin errors++; $display("FAIL err_bin: got %0d expected 0", res); end
    checks++; if (er !== 1'b1)   begin errors++; $display("FAIL err_flag: got %b expected 1", er); end
    checks++; if (lat != 1)      begin errors++; $display("FAIL err_latency: got %0d expected 1", lat); end
    checks++; if (va !== 1'b0)   begin errors++; $display("FAIL err_valid_one_cycle: got %b expected 0", va); end
  endtask

  task automatic test_stall;
    int wt, lat, rs, sb; logic [13:0] res; logic er, va, ra;
    convert(3, 16'h0512, 5, wt, lat, rs, sb, res, er, va, ra);
    checks++; if (res !== 14'd512) begin errors++; $display("FAIL stall_bin: got %0d expected 512", res); end
    checks++; if (sb != 0)         begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", sb); end
    checks++; if (va !== 1'b0)     begin errors++; $display("FAIL stall_handoff: got valid %b expected 0", va); end
    checks++; if (ra !== 1'b1)     begin errors++; $display("FAIL stall_ready_after: got %b expected 1", ra); end
  endtask

  task automatic test_reset_mid;
    int wt, lat, rs, sb, vcount; logic [13:0] res; logic er, va, ra;
    set_in(3, 16'h0777, 1'b1);
    set_ordy(3, 1'b1);
    wt = 0;
    while (!in_ready3 && wt < 100) begin @(posedge clk); #1; wt++; end
    @(posedge clk); #1;
    set_in(3, 16'h0000, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy3); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid3); end
    checks++; if (in_ready3 !== 1'b1)  begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready3); end
    checks++; if (busy3 !== 1'b0)      begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy3); end
    checks++; if (out_bin3 !== 10'd0)  begin errors++; $display("FAIL rstmid_bin: got %0d expected 0", out_bin3); end
    @(posedge clk); #3 rst_n = 1'b1;
    vcount = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid3) vcount++; end
    checks++; if (vcount != 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d valid cycles expected 0", vcount); end
    convert(3, 16'h0042, 0, wt, lat, rs, sb, res, er, va, ra);
    checks++; if (res !== 14'd42) begin errors++; $display("FAIL rstmid_next_bin: got %0d expected 42", res); end
    checks++; if (lat != 12)      begin errors++; $display("FAIL rstmid_next_latency: got %0d expected 12", lat); end
  endtask

  // Random (or exhaustive over one nibble) conversions against the model.
  task automatic test_sweep(input int d, input int n, input bit exhaustive);
    int wt, lat, rs, sb, exp_val, exp_lat; bit exp_er;
    logic [13:0] res; logic er, va, ra; logic [15:0] b;
    for (int i = 0; i < n; i++) begin
      b = exhaustive ? 16'(i) : rand_bcd(d, $urandom_range(0, 4) == 0);
      ref_conv(d, b, exp_val, exp_er);
      exp_lat = exp_er ? 1 : 4 * d;
      convert(d, b, 0, wt, lat, rs, sb, res, er, va, ra);
      checks++; if (res !== 14'(exp_val)) begin errors++; $display("FAIL sweep%0d_bin in=%h: got %0d expected %0d", d, b, res, exp_val); end
      checks++; if (er !== exp_er)       begin errors++; $display("FAIL sweep%0d_err in=%h: got %b expected %b", d, b, er, exp_er); end
      checks++; if (lat != exp_lat)      begin errors++; $display("FAIL sweep%0d_latency in=%h: got %0d expected %0d", d, b, lat, exp_lat); end
      checks++; if (va !== 1'b0)         begin errors++; $display("FAIL sweep%0d_valid_one_cycle in=%h: got %b expected 0", d, b, va); end
      checks++; if (rs != 0)             begin errors++; $display("FAIL sweep%0d_ready_while_busy in=%h: got %0d expected 0", d, b, rs); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1, 16'h0, 1'b0); set_in(3, 16'h0, 1'b0); set_in(4, 16'h0, 1'b0);
    set_ordy(1, 1'b1); set_ordy(3, 1'b1); set_ordy(4, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    test_max;
    test_back_to_back;
    test_error;
    test_stall;
    test_reset_mid;
    test_sweep(3, 60, 1'b0);
    test_sweep(1, 16, 1'b1);
    test_sweep(4, 10, 1'b0);
    test_sweep(4, 400, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
